// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the handshaked pipeline-stage register.
//               Holds the bit positions of the EX/MEM control bundle and the
//               default widths used by pipe_stage_skid and pipe_sat_cnt.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // EX/MEM control bundle layout
  localparam int CTRL_REGWRITE    = 0;
  localparam int CTRL_MEMWRITE    = 1;
  localparam int CTRL_DMTYPE_LSB  = 2;
  localparam int CTRL_DMTYPE_MSB  = 4;
  localparam int CTRL_WDSEL_LSB   = 5;
  localparam int CTRL_WDSEL_MSB   = 6;
  localparam int CTRL_W_EXMEM     = 7;

  // Default widths for a generic stage
  localparam int PIPE_DATA_W      = 32;
  localparam int PIPE_CTRL_W      = 8;
  localparam int PIPE_CNT_W       = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Saturating up-counter. Increments by one on every cycle with
//               inc_i=1 until it reaches all ones, then holds. Only reset
//               clears it.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-low reset
//               inc_i    - increment request for this cycle
//               count_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : pipe_sat_cnt
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Handshaked pipeline-stage register carrying an opaque data
//               bundle and a control bundle. Valid/ready backpressure, an
//               optional two-entry skid buffer (registered in_ready), a flush
//               that turns all held beats into a bubble, and a saturating
//               stall counter.
// Ports       : clk          - rising-edge clock
//               rst          - synchronous active-low reset
//               flush_i      - kill held beats and the beat offered this cycle
//               in_valid_i   - upstream beat present
//               in_ready_o   - stage can accept a beat this cycle
//               in_data_i    - upstream payload
//               in_ctrl_i    - upstream control bundle
//               out_valid_o  - beat presented downstream
//               out_ready_i  - downstream accepts this cycle
//               out_data_o   - payload of the head beat (holds when invalid)
//               out_ctrl_o   - control of the head beat, zero when invalid
//               stall_cnt_o  - saturating count of stalled output cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam bit HAS_SKID = (SKID != 0);

  // Main entry (head beat presented downstream)
  logic              m_v_q,    m_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;

  // Skid entry; stays permanently empty when the skid buffer is disabled
  logic              s_v_q,    s_v_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic w_accept;
  logic w_pop;
  logic w_in_ready;
  logic w_stall_inc;

  generate
    if (HAS_SKID) begin : g_skid_ready
      // Registered ready: only the skid occupancy decides, so there is no
      // combinational path from out_ready_i back to in_ready_o.
      assign w_in_ready = ~s_v_q;
    end else begin : g_direct_ready
      assign w_in_ready = ~m_v_q | out_ready_i;
    end
  endgenerate

  assign w_accept = in_valid_i & w_in_ready;
  assign w_pop    = m_v_q & out_ready_i;

  always_comb begin
    m_v_d    = m_v_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush_i) begin
      // Payload registers keep their contents; only the valid bits drop.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (HAS_SKID && s_v_q && w_pop) begin
      // Skid beat moves up; in_ready is low so nothing new can arrive.
      m_v_d    = 1'b1;
      m_data_d = s_data_q;
      m_ctrl_d = s_ctrl_q;
      s_v_d    = 1'b0;
    end else if (!m_v_q || w_pop) begin
      m_v_d = w_accept;
      if (w_accept) begin
        m_data_d = in_data_i;
        m_ctrl_d = in_ctrl_i;
      end
    end else if (HAS_SKID && w_accept) begin
      // Head is stalled but ready was still high: park the beat in the skid.
      s_v_d    = 1'b1;
      s_data_d = in_data_i;
      s_ctrl_d = in_ctrl_i;
    end

    if (!HAS_SKID) begin
      s_v_d    = 1'b0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_v_q    <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

  // Stall is judged on the state held at the edge, so a flush in the same
  // cycle still counts the stalled cycle.
  assign w_stall_inc = m_v_q & ~out_ready_i;

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_stall_inc),
    .count_o (stall_cnt_o)
  );

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = m_v_q;
  assign out_data_o  = m_data_q;
  // A bubble must never carry live control bits downstream.
  assign out_ctrl_o  = m_v_q ? m_ctrl_q : '0;

endmodule : pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register. It is the successor to the fixed-field, always-advancing inter-stage latches (EX/MEM style) in the CPU.
- Carries an opaque data bundle plus a control bundle. Adds a valid/ready handshake with backpressure, an optional 2-entry skid buffer, a flush that injects a bubble, and a saturating stall counter.
- Sits between any two pipeline stages: ID/EX, EX/MEM or MEM/WB.

Parameters:
- DATA_W, 32, width of the payload (e.g. ALU result, rs2 value, pc concatenated by the instantiator).
- CTRL_W, 8, width of the control bundle (RegWrite, MemWrite, DMType, WDSel, ...). It is forced to zero whenever no valid beat is held.
- SKID, 1. 1 = two-entry skid buffer with registered in_ready. 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-low reset.
- flush, input, 1, kill all held beats and any beat offered this cycle.
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, stage can accept a beat this cycle.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control bundle.
- out_valid, output, 1, beat presented downstream.
- out_ready, input, 1, downstream accepts this cycle.
- out_data, output, DATA_W, payload of the head beat.
- out_ctrl, output, CTRL_W, control of the head beat; all zeros when out_valid=0.
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - M = main entry {v, data, ctrl}; S = skid entry (exists only when SKID=1).
- Reset (rst=0 at a clk edge):
  - M.v=0, S.v=0, all data/ctrl registers=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Inputs are ignored while rst=0. Reset mid-transfer discards every held beat; no partial state survives.
- Outputs:
  - out_valid=M.v; out_data=M.data; out_ctrl = M.v ? M.ctrl : 0.
  - out_data is not cleared when invalid; it holds its last value.
- Latency and throughput: 1 cycle from accept to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- SKID=1, in_ready = ~S.v (registered, no combinational path from out_ready). Update priority per clk edge:
  1. flush=1: M.v<=0, S.v<=0. The beat offered this cycle is dropped even if accept=1, and it is not counted as transferred.
  2. S.v=1 and pop: M<=S, S.v<=0. No accept is possible because in_ready=0.
  3. M.v=0 or pop (with S.v=0): M<=in if accept, else M.v<=0.
  4. M.v=1, no pop, accept: S<=in (skid fills; in_ready drops next cycle).
  5. Otherwise hold.
- SKID=0:
  - in_ready = ~M.v | out_ready (combinational).
  - Rules 1, 3 and 5 only. S does not exist.
- Ordering: beats leave in exactly the order accepted. There is no duplication or loss except on flush or reset.
- Simultaneous flush and pop: the downstream stage has consumed the head beat this cycle; the stage is still empty next cycle.
- Stall counter:
  - +1 on every non-reset cycle with out_valid=1 and out_ready=0, evaluated before any flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- Control width rule: in_ctrl is captured verbatim. Zeroing happens only on the output when the entry is invalid, so a bubble can never write a register or memory.

Decomposition:
- Shared package pipe_pkg holds the bit positions of the EX/MEM control bundle:
  - CTRL_REGWRITE=0
  - CTRL_MEMWRITE=1
  - CTRL_DMTYPE=[4:2]
  - CTRL_WDSEL=[6:5]
  - CTRL_W_EXMEM=7
- Sub-module pipe_sat_cnt (parameter CNT_W; inputs clk, rst, inc; output count) is instantiated once for stall_cnt.
- The storage entries stay inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1; push in_data=1,2,3 with in_ctrl=8'h03 on consecutive cycles -> out_data=1,2,3 one cycle later each, out_ctrl=8'h03, no gaps.
- Backpressure (SKID=1):
  - Push beats A=0x10 and B=0x20 with out_ready=0 -> in_ready=0 after B; out_data holds 0x10; stall_cnt increments each stalled cycle.
  - Raise out_ready -> 0x10 then 0x20 delivered; in_ready returns to 1.
- Flush: with M and S full (A, B) and C offered on the same cycle flush=1 -> next cycle out_valid=0, out_ctrl=0; C never appears; stall_cnt retained.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays at 15.
- SKID=0: with M full and out_ready=1, accept a new beat in the same cycle -> in_ready=1 combinationally and throughput of 1/cycle is maintained.
